neural_soc_switch_poller: RTL and testbench
===========================================

# neural_soc_switch_poller

Autonomous sequencer for the 8-bit switch input PIO slave. It reads the PIO's data register at a fixed interval over a minimal Avalon-MM read path and debounces the sampled value. Each debounced change is queued as an event in a small FIFO, which the CPU drains through its own Avalon-MM slave, optionally with an interrupt. The block sits between the switch PIO and the system interconnect, so the CPU never has to busy-poll the switches.

## Interface
- POLL_CYCLES, 50000: clk cycles between consecutive PIO samples, ≥ 4.
- DEBOUNCE_COUNT, 4: consecutive identical samples required to accept a new value, 1..15.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2, 2..16.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- pio_address  out  2  address to the switch PIO slave.
- pio_readdata  in  32  PIO read data; 1-cycle registered latency, bits 7:0 valid.
- s_address  in  2  CPU slave register select.
- s_read  in  1  CPU read strobe.
- s_write  in  1  CPU write strobe.
- s_writedata  in  32  CPU write data.
- s_readdata  out  32  CPU read data; registered, valid 1 cycle after s_read.
- irq  out  1  event interrupt, level-sensitive and active-high.

## Operation
- Poll FSM states:
  - IDLE: the interval counter counts down from POLL_CYCLES-1. At 0 with enable=1, go to ADDR.
  - ADDR: drive pio_address=0 for one cycle, then go to WAIT.
  - WAIT: capture pio_readdata[7:0] as the sample, then go to EVAL.
  - EVAL: run the debounce update, then go to IDLE and reload the counter.
- pio_address is 2'b11 in every state except ADDR. At that address the PIO returns 0, which limits bus toggling.
- Debounce update:
  - If sample == last, match = min(match+1, DEBOUNCE_COUNT).
  - Otherwise, last = sample and match = 1.
  - If match (after update) == DEBOUNCE_COUNT and last != stable, push event {old=stable, new=last} and set stable = last.
- CPU registers:
  - 0 EVENT (read): pops one entry. Returns {1'b1, 15'b0, old[7:0], new[7:0]}. When empty, returns 0 with no state change.
  - 1 STABLE (read): {24'b0, stable}.
  - 2 CONTROL (read/write): bit0 enable, bit1 irq_mask.
  - 3 STATUS (read): {27'b0, overflow, count[3:0]}. Writing a 1 to bit4 clears overflow.
- Writes to addresses 0 and 1 are ignored. Reads of unused bits return 0.
- FIFO full on a push: the event is dropped and overflow is set (sticky). stable still updates.
- Push and pop in the same cycle: both take effect and count is unchanged. This holds even when the FIFO is full, in which case nothing is dropped.
- Clearing enable takes effect only in IDLE. A sample already in ADDR, WAIT or EVAL completes.
- Reset mid-poll: the FSM returns to IDLE immediately and the FIFO is emptied.

## Timing
- Reset values:
  - pio_address=2'b11, s_readdata=0, irq=0.
  - stable=0, last=0, match=0.
  - enable=1, irq_mask=0, overflow=0, FIFO empty.
  - Interval counter = POLL_CYCLES-1.
- Sample period is exactly POLL_CYCLES+3 cycles: the IDLE count plus ADDR, WAIT and EVAL.
- Debounce latency from a switch change to the event being queued is at most DEBOUNCE_COUNT+1 sample periods.
- The FIFO count updates at the clock edge that ends EVAL. The event is visible to an EVENT read issued on the next cycle.
- s_readdata is updated at the edge where s_read is high and holds its value until the next read.

## Configuration
- SWITCH_POLLER_IRQ_EN defined: irq is registered and equals irq_mask & (count != 0). It asserts 1 cycle after the push and deasserts 1 cycle after the pop that empties the FIFO.
- SWITCH_POLLER_IRQ_EN undefined: irq is constant 0, CONTROL bit1 is not stored and reads 0, and the interrupt logic is absent.

## Test plan
- Reset, then in_port held at 0x00 for 10 periods: no events, count=0, STABLE=0, pio_address=3 outside ADDR.
- Switch changes to 0xA5 and holds, DEBOUNCE_COUNT=4: exactly one event {old=0x00, new=0xA5}. STABLE=0xA5 after the 4th matching sample, not before.
- Sample sequence 0x01, 0x00, 0x01, 0x01, 0x01, 0x01: the bounce restarts match. The event {0x00, 0x01} is queued only at the 6th sample.
- Five debounced changes with FIFO_DEPTH=4 and no pops: count=4, overflow=1, and the 5th event is dropped. Writing 0x10 to STATUS clears overflow.
- EVENT pop coinciding with a push while full: count stays 4, no overflow, FIFO order preserved. A pop when empty returns 0.
- With SWITCH_POLLER_IRQ_EN defined and irq_mask=1: irq rises 1 cycle after the push and falls 1 cycle after the last pop. Clearing irq_mask forces irq=0.

Source files
------------

// File: rtl/neural_soc_switch_poller.sv
// Switch PIO poller: samples the PIO at a fixed interval, debounces, queues changes for the CPU.
// Optional interrupt output enabled by defining SWITCH_POLLER_IRQ_EN.
module neural_soc_switch_poller #(
    parameter int POLL_CYCLES    = 50000,
    parameter int DEBOUNCE_COUNT = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  pio_address,
    input  logic [31:0] pio_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);
    localparam int CW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] RELOAD = CW'(POLL_CYCLES - 1);
    localparam logic [3:0]    DC     = 4'(DEBOUNCE_COUNT);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, EVAL} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [7:0]      sample, last, stable, last_nx;
    logic [3:0]      match, match_nx;
    logic            enable, overflow, irq_mask;
    logic            ev_push, pop, full, do_push;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cnt == '0 && enable) state_nx = ADDR;
            ADDR: state_nx = WAIT;
            WAIT: state_nx = EVAL;
            EVAL: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counter reloads on wrap, so it already holds POLL_CYCLES-1 when EVAL returns to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           cnt <= RELOAD;
        else if (state == IDLE) cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
    end

    // Parking the address at 3 makes the PIO return zeros between polls.
    assign pio_address = (state == ADDR) ? 2'b00 : 2'b11;

    always_comb begin
        last_nx  = last;
        match_nx = match;
        if (sample == last) begin
            match_nx = (match >= DC) ? DC : match + 4'd1;
        end else begin
            last_nx  = sample;
            match_nx = 4'd1;
        end
        ev_push = (state == EVAL) && (match_nx == DC) && (last_nx != stable);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample <= '0;
            last   <= '0;
            match  <= '0;
            stable <= '0;
        end else begin
            if (state == WAIT) sample <= pio_readdata[7:0];
            if (state == EVAL) begin
                last  <= last_nx;
                match <= match_nx;
                if (ev_push) stable <= last_nx;
            end
        end
    end

    // A pop frees the slot the simultaneous push needs, so full+pop+push drops nothing.
    assign pop     = s_read && (s_address == 2'd0) && (count != '0);
    assign full    = (count == NW'(FIFO_DEPTH));
    assign do_push = ev_push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {stable, last_nx};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (s_write && s_address == 2'd2) enable <= s_writedata[0];
            if (ev_push && full && !pop)
                overflow <= 1'b1;
            else if (s_write && s_address == 2'd3 && s_writedata[4])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_readdata <= '0;
        end else if (s_read) begin
            case (s_address)
                2'd0:    s_readdata <= (count != '0) ? {1'b1, 15'b0, mem[rd_ptr]} : 32'b0;
                2'd1:    s_readdata <= {24'b0, stable};
                2'd2:    s_readdata <= {30'b0, irq_mask, enable};
                default: s_readdata <= {27'b0, overflow, 4'(count)};
            endcase
        end
    end

`ifdef SWITCH_POLLER_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (s_write && s_address == 2'd2) irq_mask <= s_writedata[1];
            irq_q <= irq_mask && (count != '0);
        end
    end
    assign irq = irq_q;
    logic unused_bits;
    assign unused_bits = ^{pio_readdata[31:8], s_writedata[31:5], s_writedata[3:2]};
`else
    assign irq_mask = 1'b0;
    assign irq      = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{pio_readdata[31:8], s_writedata[31:5], s_writedata[3:1]};
`endif

endmodule

// File: tb/tb_neural_soc_switch_poller.sv
// Randomized scoreboard bench for neural_soc_switch_poller with a queue-based reference model.
module tb_neural_soc_switch_poller;
    localparam int POLL = 8;
    localparam int DC   = 4;
    localparam int DEP  = 4;
    localparam int PER  = POLL + 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  pio_address;
    logic [31:0] pio_readdata = '0;
    logic [1:0]  s_address = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic        irq;
    logic [7:0]  sw = '0;

    int checks = 0;
    int failures = 0;

    neural_soc_switch_poller #(.POLL_CYCLES(POLL), .DEBOUNCE_COUNT(DC), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .reset_n(reset_n), .pio_address(pio_address), .pio_readdata(pio_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Switch PIO slave: registered read, zero unless address 0.
    always @(posedge clk) pio_readdata <= (pio_address == 2'b00) ? {24'b0, sw} : 32'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model state
    typedef struct { int due; logic [7:0] v; } pend_t;
    pend_t       pend_q[$];
    logic [7:0]  hist[$];
    logic [15:0] m_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  m_stable = '0;
    bit          m_ovf = 0, m_en = 1, m_mask = 0, irq_exp = 0, gap_ok = 0;
    int          cyc = 0, rst_cyc = 0, addr_cnt = 0, last_addr = -1;

    function automatic void m_sample(input logic [7:0] v);
        bit eq = 1;
        hist.push_back(v);
        if (hist.size() > DC) void'(hist.pop_front());
        foreach (hist[i]) if (hist[i] != v) eq = 0;
        if (hist.size() == DC && eq && v != m_stable) begin
            if (m_q.size() < DEP) m_q.push_back({m_stable, v});
            else m_ovf = 1;
            m_stable = v;
        end
    endfunction

    always @(posedge clk) begin
        logic [31:0] e;
        cyc++;
        if (!reset_n) begin
            pend_q.delete(); hist.delete(); m_q.delete(); exp_q.delete();
            m_stable = '0; m_ovf = 0; m_en = 1; m_mask = 0; irq_exp = 0;
            gap_ok = 0; last_addr = -1; rst_cyc = cyc;
        end else begin
            irq_exp = m_mask && (m_q.size() != 0);
            if (s_read) begin
                case (s_address)
                    2'd0: e = (m_q.size() > 0) ? {1'b1, 15'b0, m_q.pop_front()} : 32'b0;
                    2'd1: e = {24'b0, m_stable};
                    2'd2: e = {30'b0, m_mask, m_en};
                    default: e = {27'b0, m_ovf, 4'(m_q.size())};
                endcase
                exp_q.push_back(e);
            end
            if (s_write && s_address == 2'd2) begin
                m_en = s_writedata[0];
`ifdef SWITCH_POLLER_IRQ_EN
                m_mask = s_writedata[1];
`endif
                if (!m_en) gap_ok = 0;
            end
            if (s_write && s_address == 2'd3 && s_writedata[4]) m_ovf = 0;
            while (pend_q.size() > 0 && pend_q[0].due == cyc) m_sample(pend_q.pop_front().v);
            if (pio_address == 2'b00) begin
                addr_cnt++;
                pend_q.push_back('{cyc + 2, sw});
                if (last_addr < 0) chk("first_poll_cycle", cyc - rst_cyc, POLL + 1);
                else if (gap_ok) chk("poll_period", cyc - last_addr, PER);
                gap_ok = m_en;
                last_addr = cyc;
            end
        end
    end

    // Monitor: compare each registered read and the per-cycle outputs.
    always @(negedge clk) begin
        if (reset_n) begin
            if (exp_q.size() > 0) chk("s_readdata", s_readdata, exp_q.pop_front());
            chk("irq", {31'b0, irq}, {31'b0, irq_exp});
            chk("pio_addr_legal", {31'b0, (pio_address == 2'b00 || pio_address == 2'b11)}, 32'd1);
        end
    end

    task automatic cpu_read(input logic [1:0] a);
        @(negedge clk); s_address = a; s_read = 1'b1;
        @(negedge clk); s_read = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk); s_address = a; s_writedata = d; s_write = 1'b1;
        @(negedge clk); s_write = 1'b0;
    endtask

    task automatic wait_addr();
        int c = addr_cnt;
        int n = 0;
        while (addr_cnt == c && n < 200) begin @(negedge clk); n++; end
        if (addr_cnt == c) begin
            checks++; failures++;
            $display("FAIL poll_timeout actual=none required=poll within 200 cycles");
        end
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        sw = v;
        repeat (n) wait_addr();
    endtask

    initial begin
        automatic logic [7:0] bounce[6] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
        automatic logic [7:0] chg[5]    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        int c0;
        repeat (3) @(negedge clk);
        chk("rst_pio_address", {30'b0, pio_address}, 32'd3);
        chk("rst_s_readdata", s_readdata, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        reset_n = 1'b1;

        // Quiet input: nothing queued
        hold(8'h00, 10);
        cpu_read(2'd3); cpu_read(2'd1); cpu_read(2'd2); cpu_read(2'd0);

        // Clean change, STABLE polled after each sample
        sw = 8'hA5;
        repeat (5) begin wait_addr(); repeat (3) @(negedge clk); cpu_read(2'd1); end
        cpu_read(2'd3); cpu_read(2'd0); cpu_read(2'd0);

        hold(8'h00, 5); cpu_read(2'd0);

        // Bounce restarts the match count
        foreach (bounce[i]) begin sw = bounce[i]; wait_addr(); repeat (3) @(negedge clk); cpu_read(2'd3); end
        cpu_read(2'd1); cpu_read(2'd0);

        // Overflow, then sticky clear
        foreach (chg[i]) hold(chg[i], 4);
        repeat (3) @(negedge clk);
        cpu_read(2'd3);
        cpu_write(2'd3, 32'h10);
        cpu_read(2'd3);

        // Pop aligned with the push edge while full
        hold(8'h66, 3);
        wait_addr();
        cpu_read(2'd0);
        cpu_read(2'd3);
        repeat (5) cpu_read(2'd0);

        cpu_write(2'd2, 32'h3);
        cpu_read(2'd2);

        // Randomized switch activity and CPU traffic
        for (int it = 0; it < 150; it++) begin
            sw = (($urandom_range(0, 3) == 0) ? 8'(($urandom)) : 8'(($urandom_range(0, 3))));
            for (int k = 0, n = $urandom_range(1, 6); k < n; k++) begin
                wait_addr();
                repeat ($urandom_range(0, 6)) @(negedge clk);
                case ($urandom_range(0, 5))
                    0, 1, 2: cpu_read(2'd0);
                    3:       cpu_read(2'($urandom_range(1, 3)));
                    4:       cpu_write(2'd3, 32'h10);
                    default: cpu_write(2'd2, {30'b0, 1'($urandom), 1'b1});
                endcase
            end
        end
        repeat (DEP + 1) cpu_read(2'd0);

        // Disable: no polls once any in-flight sample finishes
        cpu_write(2'd2, 32'h0);
        repeat (PER + 2) @(negedge clk);
        c0 = addr_cnt;
        repeat (4 * PER) @(negedge clk);
        chk("disabled_no_poll", addr_cnt, c0);
        cpu_read(2'd2);
        cpu_write(2'd2, 32'h1);
        hold(8'h77, 6);
        cpu_read(2'd3);

        // Reset in the middle of a poll
        wait_addr();
        reset_n = 1'b0;
        #1;
        chk("midrst_pio_address", {30'b0, pio_address}, 32'd3);
        chk("midrst_s_readdata", s_readdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cpu_read(2'd3); cpu_read(2'd1); cpu_read(2'd0); cpu_read(2'd2);
        hold(8'h77, 6);
        cpu_read(2'd0); cpu_read(2'd3);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
